// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the framebuffer sync controller
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HOLD,
    ST_RUN
  } fb_state_e;

  // Line buffer geometry: 16 source lines held in 32 row slots.
  localparam int FB_LINES = 16;
  localparam int FB_SLOTS = 32;

  // Row distance between core writer and HDMI reader, modulo FB_SLOTS.
  localparam int LEAD_W = 5;

endpackage

// File: rtl/fb_sync_ctrl_toggle_sync.sv
// rtl/fb_sync_ctrl_toggle_sync.sv - 3-flop toggle synchronizer producing a one-cycle pulse
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic tgl_in,
  output logic pulse
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the foreign-domain toggle through three stages.
  always_comb begin
    sync_d = {sync_q[1:0], tgl_in};
  end

  // Synchronizer stages; stage 1 is the metastability catcher.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Any change between stage 2 and stage 3 marks one toggle event.
  assign pulse = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/fb_sync_ctrl.sv
// rtl/fb_sync_ctrl.sv - paces the video core against HDMI scanout of the line buffer
module fb_sync_ctrl
  import fb_pkg::*;
#(
  parameter int HEIGHT      = 240,
  parameter int WIDTH       = 320,
  parameter int LEAD_MAX    = 12,
  parameter int RESYNC_LINE = 100,
  parameter int TIMEOUT     = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(WIDTH)-1:0]  x,
  input  logic [$clog2(HEIGHT)-1:0] y,
  input  logic                      hdmi_frame_tgl,
  input  logic                      hdmi_row_tgl,
  input  logic                      enable,
  output logic                      pause_core,
  output logic                      locked,
  output logic [LEAD_W-1:0]         lead,
  output logic                      underrun,
  output logic                      sync_timeout,
  input  logic                      clr_status
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic frame_p;
  logic row_p;

  fb_state_e         state_q, state_d;
  logic              pause_q, pause_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LEAD_W-1:0] hdmi_row_q, hdmi_row_d;
  logic [LEAD_W-1:0] lead_q, lead_d;
  logic              underrun_q, underrun_d;
  logic              timeout_q, timeout_d;
  logic              underrun_set;
  logic              timeout_set;
  logic              at_line1;
  logic              at_resync;
  logic              y_low;
  logic              lead_neg;

  toggle_sync u_frame_sync (
    .clk    (clk),
    .reset  (reset),
    .tgl_in (hdmi_frame_tgl),
    .pulse  (frame_p)
  );

  toggle_sync u_row_sync (
    .clk    (clk),
    .reset  (reset),
    .tgl_in (hdmi_row_tgl),
    .pulse  (row_p)
  );

  assign at_line1  = (y == YW'(1)) && (x == XW'(0));
  assign at_resync = (y == YW'(RESYNC_LINE)) && (x == XW'(0));
  assign y_low     = (y < YW'(2));
  // A lead of half the slot ring or more means the reader is actually ahead.
  assign lead_neg  = (lead_q >= LEAD_W'(FB_LINES));

  // Track the HDMI read row and the core-minus-reader distance; a new frame restarts the reader.
  always_comb begin
    hdmi_row_d = hdmi_row_q;
    if (frame_p) begin
      hdmi_row_d = '0;
    end else if (row_p) begin
      hdmi_row_d = hdmi_row_q + LEAD_W'(1);
    end
    lead_d = y[LEAD_W-1:0] - hdmi_row_d;
  end

  // Scheduler: lock to HDMI frame start, throttle on excess lead, catch underrun.
  always_comb begin
    state_d      = state_q;
    pause_d      = pause_q;
    cnt_d        = cnt_q;
    underrun_set = 1'b0;
    timeout_set  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      pause_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pause_d = 1'b0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          pause_d = 1'b0;
          if (at_line1) begin
            pause_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          pause_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (frame_p) begin
            pause_d = 1'b0;
            state_d = ST_RUN;
          end else if (cnt_q == TO_LAST) begin
            timeout_set = 1'b1;
            pause_d     = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!y_low && lead_neg) begin
            underrun_set = 1'b1;
            pause_d      = 1'b0;
            state_d      = ST_ARM;
          end else if (at_resync) begin
            pause_d = 1'b0;
            state_d = ST_ARM;
          end else begin
            pause_d = (lead_q >= LEAD_W'(LEAD_MAX)) && !lead_neg;
          end
        end
        default: begin
          pause_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as a clear takes priority.
  always_comb begin
    underrun_d = underrun_q;
    timeout_d  = timeout_q;
    if (clr_status) begin
      underrun_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pause_q    <= 1'b0;
      cnt_q      <= '0;
      hdmi_row_q <= '0;
      lead_q     <= '0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pause_q    <= pause_d;
      cnt_q      <= cnt_d;
      hdmi_row_q <= hdmi_row_d;
      lead_q     <= lead_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pause_core   = pause_q;
  assign locked       = (state_q == ST_RUN);
  assign lead         = lead_q;
  assign underrun     = underrun_q;
  assign sync_timeout = timeout_q;

endmodule

// File: tb/tb_fb_sync_ctrl.sv
// tb/tb_fb_sync_ctrl.sv - directed self-checking bench for fb_sync_ctrl
module tb_fb_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] x;
  logic [7:0] y;
  logic       hdmi_frame_tgl;
  logic       hdmi_row_tgl;
  logic       enable;
  logic       pause_core;
  logic       locked;
  logic [4:0] lead;
  logic       underrun;
  logic       sync_timeout;
  logic       clr_status;

  int n_checks = 0;
  int n_err    = 0;
  int cnt;

  fb_sync_ctrl #(
    .HEIGHT      (240),
    .WIDTH       (320),
    .LEAD_MAX    (12),
    .RESYNC_LINE (100),
    .TIMEOUT     (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .x              (x),
    .y              (y),
    .hdmi_frame_tgl (hdmi_frame_tgl),
    .hdmi_row_tgl   (hdmi_row_tgl),
    .enable         (enable),
    .pause_core     (pause_core),
    .locked         (locked),
    .lead           (lead),
    .underrun       (underrun),
    .sync_timeout   (sync_timeout),
    .clr_status     (clr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input int budget, output int cycles);
    cycles = 0;
    while (!locked && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    x              = '0;
    y              = '0;
    hdmi_frame_tgl = 1'b0;
    hdmi_row_tgl   = 1'b0;
    clr_status     = 1'b0;
    repeat (2) tick();
    check("rst_pause", pause_core, 0);
    check("rst_locked", locked, 0);
    check("rst_lead", lead, 0);
    check("rst_underrun", underrun, 0);
    check("rst_timeout", sync_timeout, 0);

    // Bypass: no pause while disabled, even at line 1.
    reset = 1'b0;
    y = 8'd1; x = 9'd0;
    repeat (2) tick();
    check("bypass_pause", pause_core, 0);

    // Arm and lock.
    y = 8'd5; x = 9'd3;
    enable = 1'b1;
    tick();
    check("arm_pause", pause_core, 0);
    check("arm_locked", locked, 0);
    y = 8'd1; x = 9'd0;
    tick();
    check("hold_pause", pause_core, 1);
    x = 9'd1;
    hdmi_frame_tgl = ~hdmi_frame_tgl;
    wait_locked(10, cnt);
    check("lock_within_4", (cnt <= 4) && locked, 1);
    check("lock_unpause", pause_core, 0);

    // Throttle on lead reaching LEAD_MAX with reader parked at row 0.
    y = 8'd11; x = 9'd5;
    tick();
    check("lead_11", lead, 11);
    tick();
    check("run_lead11_pause", pause_core, 0);
    y = 8'd12;
    tick();
    check("lead_12", lead, 12);
    check("pause_not_early", pause_core, 0);
    tick();
    check("pause_at_12", pause_core, 1);
    hdmi_row_tgl = ~hdmi_row_tgl;
    cnt = 0;
    while (pause_core && cnt < 10) begin
      tick();
      cnt++;
    end
    check("unpause_within_4", (cnt <= 4) && !pause_core, 1);
    check("lead_back_11", lead, 11);

    // Underrun: reader at row 5, core drops to row 3.
    y = 8'd13;
    repeat (4) begin
      hdmi_row_tgl = ~hdmi_row_tgl;
      repeat (4) tick();
    end
    check("lead_8", lead, 8);
    y = 8'd3;
    tick();
    check("lead_30", lead, 30);
    tick();
    check("underrun_set", underrun, 1);
    check("underrun_locked", locked, 0);
    check("underrun_pause", pause_core, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("underrun_clr", underrun, 0);

    // Timeout in HOLD without a frame toggle (state ARM after underrun).
    y = 8'd1; x = 9'd0;
    tick();
    check("rearm_pause", pause_core, 1);
    x = 9'd1;
    cnt = 0;
    while (!sync_timeout && cnt < 300) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, 100);
    check("timeout_pause", pause_core, 0);
    check("timeout_locked", locked, 0);

    // Resync at RESYNC_LINE and relock at line 1.
    tick();
    y = 8'd1; x = 9'd0;
    tick();
    check("relock_hold", pause_core, 1);
    x = 9'd1;
    hdmi_frame_tgl = ~hdmi_frame_tgl;
    wait_locked(10, cnt);
    check("relock_locked", locked, 1);
    y = 8'd100; x = 9'd0;
    tick();
    check("resync_lead", lead, 4);
    check("resync_locked", locked, 0);
    check("resync_no_underrun", underrun, 0);
    y = 8'd1; x = 9'd0;
    tick();
    check("resync_repause", pause_core, 1);

    // Simultaneous frame and row pulses: the clear wins.
    x = 9'd1;
    hdmi_row_tgl = ~hdmi_row_tgl;
    repeat (4) tick();
    check("row_one_lead", lead, 0);
    hdmi_row_tgl   = ~hdmi_row_tgl;
    hdmi_frame_tgl = ~hdmi_frame_tgl;
    repeat (4) tick();
    check("same_cycle_clear", lead, 1);
    check("same_cycle_locked", locked, 1);

    // Disable from RUN.
    enable = 1'b0;
    tick();
    check("disable_locked", locked, 0);
    check("disable_pause", pause_core, 0);

    // Asynchronous reset in the middle of HOLD.
    enable = 1'b1;
    tick();
    y = 8'd1; x = 9'd0;
    tick();
    check("pre_rst_hold", pause_core, 1);
    y = 8'd9; x = 9'd5;
    tick();
    check("pre_rst_lead", lead, 9);
    check("pre_rst_timeout", sync_timeout, 1);
    reset = 1'b1;
    #1;
    check("async_rst_pause", pause_core, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_lead", lead, 0);
    check("async_rst_timeout", sync_timeout, 0);
    check("async_rst_underrun", underrun, 0);
    tick();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_sync_ctrl.md
Name: fb_sync_ctrl

Overview:
- Core-clock-domain scheduler that paces the video core against the HDMI scanout of the 16-line (32-row-slot) BRAM line buffer.
- Replaces the ad-hoc pause logic. Does three things:
  - Locks core frame start to HDMI frame start.
  - Throttles the core whenever it runs too far ahead of the HDMI reader.
  - Flags underrun (reader overtook writer).
- Sits between the core's x/y counters and the framebuffer's pause_core input.

Parameters:
- HEIGHT, 240, max source frame height; sets y width.
- WIDTH, 320, max source frame width; sets x width.
- LEAD_MAX, 12, max rows the core may be ahead of the HDMI read row before it is paused (must be < 16).
- RESYNC_LINE, 100, source line at which the lock is re-armed each frame.
- TIMEOUT, 2000000, core clocks to wait in HOLD before giving up.

Ports:
- clk  in  1  core (megadrive) clock
- reset  in  1  asynchronous active-high reset
- x  in  $clog2(WIDTH)  current core pixel column
- y  in  $clog2(HEIGHT)  current core line
- hdmi_frame_tgl  in  1  toggles once per HDMI frame at first active 4:3 line (clk_pixel domain)
- hdmi_row_tgl  in  1  toggles each time the HDMI reader advances one source row (clk_pixel domain)
- enable  in  1  0 = bypass; core never paused
- pause_core  out  1  stall request to core
- locked  out  1  in RUN state
- lead  out  5  core row minus HDMI read row, modulo 32
- underrun  out  1  sticky: reader caught the writer
- sync_timeout  out  1  sticky: HOLD exceeded TIMEOUT
- clr_status  in  1  clears both sticky flags

Behaviour:
- Reset (async, active-high): all outputs are 0; state is IDLE; row counters are 0.
- CDC:
  - Both toggles pass through a 3-flop synchronizer.
  - An edge is stage2 XOR stage3, giving a one-cycle pulse: frame_p or row_p.
  - Latency from toggle to pulse is 2-3 clk.
- hdmi_row:
  - 5-bit counter. Cleared on frame_p; +1 on row_p.
  - If frame_p and row_p occur in the same cycle, the clear wins.
- core_row: y[4:0].
- lead = core_row - hdmi_row, 5-bit wrap.
- States:
  - IDLE: pause_core=0. Goes to ARM when enable=1.
  - ARM:
    - When y==1 && x==0: pause_core<=1, go to HOLD, clear the timeout counter.
  - HOLD:
    - pause_core=1; the timeout counter increments each cycle.
    - On frame_p: pause_core<=0 on the next clk; go to RUN.
    - If the counter reaches TIMEOUT-1 first: sync_timeout<=1, pause_core<=0, go to IDLE.
  - RUN: locked=1.
    - pause_core<=1 when lead>=LEAD_MAX and lead<16.
    - pause_core<=0 when lead<LEAD_MAX.
    - The pause decision is registered, i.e. one cycle after lead changes.
    - If lead>=16 (reader ahead, negative lead): underrun<=1, pause_core<=0, go to ARM.
    - On y==RESYNC_LINE && x==0: go to ARM, which re-locks at line 1 of the next frame.
- Underrun check is suppressed while y<2 (frame start, where both counters reset).
- enable=0 in any state: next cycle goes to IDLE with pause_core=0 and locked=0.
- clr_status clears underrun and sync_timeout. If it coincides with a set event, the set wins.
- The core must be ~0.x% faster than HDMI; steady-state lead oscillates below LEAD_MAX.

Decomposition:
- Shared package fb_pkg holds:
  - the state enum (IDLE, ARM, HOLD, RUN);
  - FB_LINES=16 and FB_SLOTS=32;
  - the lead width constant (5).
- One sub-module, toggle_sync: 3-flop toggle synchronizer with a pulse output, instantiated twice.

Test Plan:
- Reset mid-HOLD → pause_core, locked, lead and flags all 0 immediately (async), state IDLE.
- enable=1; drive y=1,x=0 → pause_core=1 within 1 clk. Toggle hdmi_frame_tgl → pause_core=0 and locked=1 within 4 clk.
- RUN with hdmi_row held at 0, core advances y to 12 → pause_core=1 one cycle after lead=12. One row toggle (lead=11) → pause_core=0 within 4 clk.
- RUN with hdmi_row toggled to 5 while core_row=3 (lead=30) → underrun=1, state ARM, pause_core=0. clr_status → underrun=0.
- HOLD with no frame toggle, TIMEOUT=100 → sync_timeout=1 and pause_core=0 at cycle 100.
- y reaches RESYNC_LINE=100 → state ARM, locked=0. Next y=1,x=0 re-pauses. frame_p and row_p in the same cycle → hdmi_row=0.
